id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1: decode stage presents a valid instruction.
REQ-004 SHALL have ports in_rd1 and in_rd2, input, 32 each: register-file read data for rs1 and rs2.
REQ-005 SHALL have port in_imm, input, 32: sign-extended immediate.
REQ-006 SHALL have ports in_rs1, in_rs2 and in_rd, input, 5 each: source and destination register indices.
REQ-007 SHALL have port in_aluControl, input, 4: ALU operation code (0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLL).
REQ-008 SHALL have ports in_aluSrc, in_regWrite and in_memRead, input, 1 each: immediate select, register writeback, load.
REQ-009 SHALL have ports stall and flush, input, 1 each: external hold; squash the stage contents.
REQ-010 SHALL have ports exmem_rd (5), exmem_regWrite (1) and exmem_result (32), input: forwarding source 1.
REQ-011 SHALL have ports memwb_rd (5), memwb_regWrite (1) and memwb_result (32), input: forwarding source 2.
REQ-012 SHALL have ports srcA and srcB, output, 32 each: ALU operands.
REQ-013 SHALL have port aluControl, output, 4: registered operation code.
REQ-014 SHALL have ports ex_rd (5), ex_regWrite (1), ex_memRead (1), ex_valid (1) and ex_storeData (32), output: registered control fields and forwarded rs2 data.
REQ-015 SHALL have port load_use_stall, output, 1: asks the fetch and decode stages to hold.

Function
REQ-016 SHALL register all in_* fields on a clock edge when stall=0, flush=0 and load_use_stall=0; latency is 1 cycle.
REQ-017 SHALL hold every register unchanged when stall=1 and flush=0.
REQ-018 SHALL clear ex_valid, ex_regWrite and ex_memRead at the next edge when flush=1; flush overrides stall and load_use_stall.
REQ-019 SHALL drive load_use_stall=1 combinationally when all of the following hold: ex_valid=1, ex_memRead=1, ex_rd!=0, in_valid=1, and ex_rd equals in_rs1 or in_rs2.
REQ-020 SHALL, while load_use_stall=1 and flush=0, insert a bubble: ex_valid, ex_regWrite and ex_memRead go to 0 and the in_* fields are not captured.
REQ-021 SHALL compute fwdA from the registered rs1 as follows:
- exmem_result if exmem_regWrite=1, exmem_rd!=0 and exmem_rd equals rs1;
- else memwb_result if memwb_regWrite=1, memwb_rd!=0 and memwb_rd equals rs1;
- else registered rd1.
REQ-022 SHALL compute fwdB the same way from the registered rs2 and rd2.
REQ-023 SHALL drive srcA=fwdA; srcB=registered imm when aluSrc=1, else fwdB; ex_storeData=fwdB always.
REQ-024 SHALL never forward onto register 0; an operand with index 0 reads registered rd1 or rd2 unchanged.
REQ-025 SHALL drive outputs of the bubble (ex_valid=0) with their regWrite and memRead cleared; data fields are don't-care.

Reset
REQ-026 SHALL on rst_n=0 asynchronously clear every register to 0: ex_valid=0, aluControl=0000, ex_rd=0, and srcA=srcB=0 absent forwarding.
REQ-027 SHALL, on reset asserted mid-stall or mid-bubble, discard the held instruction; the first valid capture occurs on the first edge after rst_n rises.

Configuration
REQ-028 SHALL, when macro ID_EX_FWD_EN is defined, implement forwarding per REQ-021..REQ-024.
REQ-029 SHALL, when ID_EX_FWD_EN is undefined, set fwdA=registered rd1 and fwdB=registered rd2 with the exmem_*/memwb_* inputs ignored; load_use_stall behaviour is unchanged.

Verification
REQ-030 SHALL cover forwarding from EX/MEM: registered rs1=5, exmem_rd=5, exmem_regWrite=1, exmem_result=0x0000_00AA, rd1=0x11 -> srcA=0x0000_00AA.
REQ-031 SHALL cover forwarding priority: rs2=7 matches both exmem_result=0x22 and memwb_result=0x33, aluSrc=0 -> srcB=0x22 and ex_storeData=0x22.
REQ-032 SHALL cover the x0 guard: rs1=0, exmem_rd=0, exmem_regWrite=1, exmem_result=0xFFFF_FFFF, rd1=0 -> srcA=0.
REQ-033 SHALL cover load-use: a load with ex_rd=3 followed by in_rs1=3 -> load_use_stall=1 for exactly 1 cycle, ex_valid=0 for 1 cycle, then the instruction is captured with forwarding from memwb.
REQ-034 SHALL cover stall with flush: stall=1 and flush=1 on the same edge -> ex_valid=0 next cycle; stall=1 alone holds srcA, srcB and aluControl for N cycles.
REQ-035 SHALL cover async reset: rst_n low mid-cycle during stall -> ex_valid=0 and aluControl=0000 immediately, before the next edge.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX pipeline bundle: decode-side inputs, forwarding sources and EX-side outputs.
interface id_ex_if;
  logic        in_valid;
  logic [31:0] in_rd1;
  logic [31:0] in_rd2;
  logic [31:0] in_imm;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [3:0]  in_aluControl;
  logic        in_aluSrc;
  logic        in_regWrite;
  logic        in_memRead;
  logic        stall;
  logic        flush;
  logic [4:0]  exmem_rd;
  logic        exmem_regWrite;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_regWrite;
  logic [31:0] memwb_result;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [3:0]  aluControl;
  logic [4:0]  ex_rd;
  logic        ex_regWrite;
  logic        ex_memRead;
  logic        ex_valid;
  logic [31:0] ex_storeData;
  logic        load_use_stall;

  modport master (
    output in_valid, in_rd1, in_rd2, in_imm, in_rs1, in_rs2, in_rd,
           in_aluControl, in_aluSrc, in_regWrite, in_memRead, stall, flush,
           exmem_rd, exmem_regWrite, exmem_result,
           memwb_rd, memwb_regWrite, memwb_result,
    input  srcA, srcB, aluControl, ex_rd, ex_regWrite, ex_memRead, ex_valid,
           ex_storeData, load_use_stall
  );

  modport slave (
    input  in_valid, in_rd1, in_rd2, in_imm, in_rs1, in_rs2, in_rd,
           in_aluControl, in_aluSrc, in_regWrite, in_memRead, stall, flush,
           exmem_rd, exmem_regWrite, exmem_result,
           memwb_rd, memwb_regWrite, memwb_result,
    output srcA, srcB, aluControl, ex_rd, ex_regWrite, ex_memRead, ex_valid,
           ex_storeData, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand forwarding.
// Forwarding from EX/MEM and MEM/WB is built only when ID_EX_FWD_EN is defined.
module id_ex_stage (
  input  logic    clk,
  input  logic    rst_n,
  id_ex_if.slave  bus
);

  logic        r_valid;
  logic        r_regWrite;
  logic        r_memRead;
  logic        r_aluSrc;
  logic [3:0]  r_alu;
  logic [4:0]  r_rd;
  logic [31:0] r_imm;
  logic [4:0]  r_rs   [2];
  logic [31:0] r_rdat [2];
  logic [31:0] w_fwd  [2];
  logic        w_load_use;

  // A load in EX whose result is needed by the instruction in decode cannot be forwarded in time.
  assign w_load_use = r_valid && r_memRead && (r_rd != 5'd0) && bus.in_valid &&
                      ((r_rd == bus.in_rs1) || (r_rd == bus.in_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
      r_aluSrc   <= 1'b0;
      r_alu      <= 4'd0;
      r_rd       <= 5'd0;
      r_imm      <= 32'd0;
      r_rs[0]    <= 5'd0;
      r_rs[1]    <= 5'd0;
      r_rdat[0]  <= 32'd0;
      r_rdat[1]  <= 32'd0;
    end else if (bus.flush || (!bus.stall && w_load_use)) begin
      // Squash or bubble: only the control bits matter, data fields keep their old value.
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
    end else if (!bus.stall) begin
      r_valid    <= bus.in_valid;
      r_regWrite <= bus.in_valid & bus.in_regWrite;
      r_memRead  <= bus.in_valid & bus.in_memRead;
      r_aluSrc   <= bus.in_aluSrc;
      r_alu      <= bus.in_aluControl;
      r_rd       <= bus.in_rd;
      r_imm      <= bus.in_imm;
      r_rs[0]    <= bus.in_rs1;
      r_rs[1]    <= bus.in_rs2;
      r_rdat[0]  <= bus.in_rd1;
      r_rdat[1]  <= bus.in_rd2;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef ID_EX_FWD_EN
      // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
      always_comb begin
        w_fwd[gi] = r_rdat[gi];
        if (bus.exmem_regWrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == r_rs[gi]))
          w_fwd[gi] = bus.exmem_result;
        else if (bus.memwb_regWrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == r_rs[gi]))
          w_fwd[gi] = bus.memwb_result;
      end
`else
      assign w_fwd[gi] = r_rdat[gi];
`endif
    end
  endgenerate

`ifndef ID_EX_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus.exmem_rd, bus.exmem_regWrite, bus.exmem_result,
                          bus.memwb_rd, bus.memwb_regWrite, bus.memwb_result,
                          r_rs[0], r_rs[1]};
`endif

  assign bus.srcA           = w_fwd[0];
  assign bus.srcB           = r_aluSrc ? r_imm : w_fwd[1];
  assign bus.ex_storeData   = w_fwd[1];
  assign bus.aluControl     = r_alu;
  assign bus.ex_rd          = r_rd;
  assign bus.ex_regWrite    = r_regWrite;
  assign bus.ex_memRead     = r_memRead;
  assign bus.ex_valid       = r_valid;
  assign bus.load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a queue scoreboard of expected EX-side outputs.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  id_ex_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        v;
    logic        rw;
    logic        mr;
    logic        data;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  exp_t  last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rdat);
`ifdef ID_EX_FWD_EN
    if (bus.exmem_regWrite && bus.exmem_rd != 5'd0 && bus.exmem_rd == rs) return bus.exmem_result;
    if (bus.memwb_regWrite && bus.memwb_rd != 5'd0 && bus.memwb_rd == rs) return bus.memwb_result;
`endif
    return rdat;
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic [3:0] alu, input logic src, input logic rw, input logic mr);
    bus.in_valid = 1'b1; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
    bus.in_rd1 = rd1; bus.in_rd2 = rd2; bus.in_imm = imm; bus.in_aluControl = alu;
    bus.in_aluSrc = src; bus.in_regWrite = rw; bus.in_memRead = mr;
  endtask

  task automatic set_fwd(input logic [4:0] xr, input logic xw, input logic [31:0] xres,
                         input logic [4:0] mr, input logic mw, input logic [31:0] mres);
    bus.exmem_rd = xr; bus.exmem_regWrite = xw; bus.exmem_result = xres;
    bus.memwb_rd = mr; bus.memwb_regWrite = mw; bus.memwb_result = mres;
  endtask

  // Expected outputs for a capture of the currently driven decode fields.
  task automatic push_cap(input string tag);
    exp_t e;
    e.a    = fwd(bus.in_rs1, bus.in_rd1);
    e.sd   = fwd(bus.in_rs2, bus.in_rd2);
    e.b    = bus.in_aluSrc ? bus.in_imm : e.sd;
    e.alu  = bus.in_aluControl;
    e.rd   = bus.in_rd;
    e.v    = 1'b1;
    e.rw   = bus.in_regWrite;
    e.mr   = bus.in_memRead;
    e.data = 1'b1;
    last = e;
    q.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic push_bubble(input string tag);
    exp_t e;
    e = '0;
    q.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic push_hold(input string tag);
    q.push_back(last);
    tq.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=0 entries expected=1 entry");
      return;
    end
    e = q.pop_front();
    t = tq.pop_front();
    check({t, ".ex_valid"},    32'(bus.ex_valid),    32'(e.v));
    check({t, ".ex_regWrite"}, 32'(bus.ex_regWrite), 32'(e.rw));
    check({t, ".ex_memRead"},  32'(bus.ex_memRead),  32'(e.mr));
    if (e.data) begin
      check({t, ".srcA"},         bus.srcA,                e.a);
      check({t, ".srcB"},         bus.srcB,                e.b);
      check({t, ".ex_storeData"}, bus.ex_storeData,        e.sd);
      check({t, ".aluControl"},   32'(bus.aluControl),     32'(e.alu));
      check({t, ".ex_rd"},        32'(bus.ex_rd),          32'(e.rd));
    end
    $display("txn %s valid=%b rw=%b mr=%b srcA=%h srcB=%h store=%h alu=%h rd=%0d",
             t, bus.ex_valid, bus.ex_regWrite, bus.ex_memRead, bus.srcA, bus.srcB,
             bus.ex_storeData, bus.aluControl, bus.ex_rd);
  endtask

  initial begin
    drive(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

    // Reset state
    tick(); tick();
    check("reset.ex_valid",   32'(bus.ex_valid),       32'd0);
    check("reset.aluControl", 32'(bus.aluControl),     32'd0);
    check("reset.ex_rd",      32'(bus.ex_rd),          32'd0);
    check("reset.srcA",       bus.srcA,                32'd0);
    check("reset.srcB",       bus.srcB,                32'd0);
    check("reset.load_use",   32'(bus.load_use_stall), 32'd0);
    $display("txn reset valid=%b alu=%h", bus.ex_valid, bus.aluControl);
    rst_n = 1'b1;

    // Plain register-register and register-immediate captures
    drive(5'd1, 5'd2, 5'd4, 32'h100, 32'h200, 32'h5, 4'b0000, 1'b0, 1'b1, 1'b0);
    push_cap("add"); tick(); pop_check();
    drive(5'd2, 5'd6, 5'd8, 32'h1234_5678, 32'hDEAD_BEEF, 32'h3, 4'b0101, 1'b1, 1'b1, 1'b0);
    push_cap("sll_imm"); tick(); pop_check();

    // EX/MEM forwarding onto rs1
    set_fwd(5'd5, 1'b1, 32'h0000_00AA, 5'd0, 1'b0, 32'd0);
    drive(5'd5, 5'd2, 5'd9, 32'h11, 32'h44, 32'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
    push_cap("fwd_exmem"); tick(); pop_check();

    // EX/MEM wins over MEM/WB on rs2
    set_fwd(5'd7, 1'b1, 32'h22, 5'd7, 1'b1, 32'h33);
    drive(5'd1, 5'd7, 5'd10, 32'h1, 32'h77, 32'h0, 4'b0010, 1'b0, 1'b1, 1'b0);
    push_cap("fwd_priority"); tick(); pop_check();

    // x0 is never forwarded
    set_fwd(5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'hFFFF_FFFF);
    drive(5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 4'b0011, 1'b0, 1'b1, 1'b0);
    push_cap("x0_guard"); tick(); pop_check();

    // MEM/WB only
    set_fwd(5'd8, 1'b1, 32'h88, 5'd9, 1'b1, 32'h99);
    drive(5'd9, 5'd3, 5'd12, 32'h5, 32'h6, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    push_cap("fwd_memwb"); tick(); pop_check();
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

    // Load-use: one bubble, then capture with MEM/WB forwarding of the load result
    drive(5'd1, 5'd0, 5'd3, 32'h1000, 32'h0, 32'h8, 4'b0000, 1'b1, 1'b1, 1'b1);
    push_cap("load"); tick(); pop_check();
    drive(5'd3, 5'd0, 5'd5, 32'h0BAD, 32'h2, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1;
    check("lu.stall_asserted", 32'(bus.load_use_stall), 32'd1);
    push_bubble("lu_bubble"); tick(); pop_check();
    check("lu.stall_released", 32'(bus.load_use_stall), 32'd0);
    set_fwd(5'd0, 1'b0, 32'd0, 5'd3, 1'b1, 32'h3333);
    push_cap("lu_capture"); tick(); pop_check();
    check("lu.no_second_stall", 32'(bus.load_use_stall), 32'd0);
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

    // Stall holds for three cycles, then stall+flush squashes
    drive(5'd4, 5'd5, 5'd13, 32'hCAFE, 32'hF00D, 32'h0, 4'b0011, 1'b0, 1'b1, 1'b0);
    push_cap("pre_stall"); tick(); pop_check();
    drive(5'd6, 5'd7, 5'd14, 32'h1, 32'h2, 32'h3, 4'b0001, 1'b1, 1'b1, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_hold("stall_hold"); tick(); pop_check();
    end
    bus.flush = 1'b1;
    push_bubble("stall_flush"); tick(); pop_check();
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Flush alone squashes a valid incoming instruction
    drive(5'd1, 5'd2, 5'd15, 32'h10, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b1);
    push_cap("pre_flush"); tick(); pop_check();
    bus.flush = 1'b1;
    push_bubble("flush"); tick(); pop_check();
    bus.flush = 1'b0;

    // Async reset mid-cycle during a stall
    drive(5'd1, 5'd2, 5'd6, 32'h55, 32'h66, 32'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
    push_cap("pre_reset"); tick(); pop_check();
    bus.stall = 1'b1;
    push_hold("reset_stall"); tick(); pop_check();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.ex_valid",   32'(bus.ex_valid),   32'd0);
    check("async_rst.aluControl", 32'(bus.aluControl), 32'd0);
    check("async_rst.srcA",       bus.srcA,            32'd0);
    $display("txn async_reset valid=%b alu=%h", bus.ex_valid, bus.aluControl);
    #2;
    rst_n = 1'b1;
    bus.stall = 1'b0;
    drive(5'd2, 5'd1, 5'd7, 32'h77, 32'h88, 32'h0, 4'b0010, 1'b0, 1'b1, 1'b0);
    push_cap("post_reset"); tick(); pop_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
